// File: rtl/fb_port_arbiter.sv
// Framebuffer port arbiter. Shares one single-port RAM between the HDMI pixel
// fetcher (default winner) and the processor. The processor is guaranteed a slot
// after it has waited WAIT_MAX cycles. Read data is routed back through a
// two-stage owner-tag pipeline that follows the RAM's one-cycle read latency.
module fb_port_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 8,
  parameter int WAIT_MAX = 8    // 1..255
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low

  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,

  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Which requester a RAM read belongs to (writes carry no tag).
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  localparam logic [7:0] STARVE_LIM = 8'(WAIT_MAX);

  logic [7:0]        r_starve_cnt;
  logic              w_starved;
  logic              w_cpu_gnt;
  logic              w_disp_gnt;
  owner_e            w_tag_in;
  owner_e            r_tag_s1;
  owner_e            r_tag_s2;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_wdata;

  assign w_starved = (r_starve_cnt == STARVE_LIM);

  // Grants are combinational in the request cycle; reset masks them directly so
  // they fall the moment rst goes low rather than waiting for a clock edge.
  assign w_cpu_gnt  = rst & cpu_req & (~disp_req | w_starved);
  assign w_disp_gnt = rst & disp_req & ~w_cpu_gnt;

  assign disp_gnt = w_disp_gnt;
  assign cpu_gnt  = w_cpu_gnt;

  // Tag for the access issued this cycle: only reads expect data back.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    w_tag_in = OWN_NONE;
    if (w_disp_gnt)
      w_tag_in = OWN_DISP;
    else if (w_cpu_gnt && !cpu_we)
      w_tag_in = OWN_CPU;
  end

  // CPU starvation counter: counts waiting cycles, saturates, clears on grant or idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      r_starve_cnt <= '0;
    end else if (w_cpu_gnt || !cpu_req) begin
      r_starve_cnt <= '0;
    end else if (!w_starved) begin
      r_starve_cnt <= r_starve_cnt + 8'd1;
    end
  end

  // RAM command register: launches the granted access so the RAM sees it next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_we <= w_cpu_gnt & cpu_we;
      if (w_cpu_gnt) begin
        r_mem_addr <= cpu_addr;
        if (cpu_we)
          r_mem_wdata <= cpu_wdata;
      end else if (w_disp_gnt) begin
        r_mem_addr <= disp_addr;
      end
    end
  end

  // Owner-tag pipeline: stage 1 aligns with the RAM address, stage 2 with its data.
  // Clearing it on reset discards any read still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tag_s1 <= OWN_NONE;
      r_tag_s2 <= OWN_NONE;
    end else begin
      r_tag_s1 <= w_tag_in;
      r_tag_s2 <= r_tag_s1;
    end
  end

  assign mem_addr  = r_mem_addr;
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_mem_wdata;

  // Route RAM data only to the owner; the other port sees a steady 0.
  assign disp_rvalid = (r_tag_s2 == OWN_DISP);
  assign cpu_rvalid  = (r_tag_s2 == OWN_CPU);
  assign disp_rdata  = disp_rvalid ? mem_rdata : '0;
  assign cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Self-checking bench for fb_port_arbiter: a behavioural RAM, a reference model
// that predicts grants and read responses from the arbitration rules, and a
// monitor that pops predicted responses whenever a port presents rvalid.
module tb_fb_port_arbiter;

  localparam int ADDR_W   = 18;
  localparam int DATA_W   = 8;
  localparam int WAIT_MAX = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt, disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt, cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  fb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: registered read, data one cycle after address.
  bit [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int              due;
    logic [DATA_W-1:0] data;
  } rd_t;

  rd_t dq[$];
  rd_t cq[$];

  bit [DATA_W-1:0] model_mem [0:(1<<ADDR_W)-1];
  int              cpu_wait = 0;
  bit              exp_d, exp_c;
  bit              m_we = 1'b0;
  logic [ADDR_W-1:0] m_addr = '0;
  logic [DATA_W-1:0] m_wdata = '0;
  bit              last_d = 1'b0, last_c = 1'b0;
  int              n_dgnt = 0, n_cgnt = 0, n_we = 0;

  // Predict this cycle's grants and RAM command, queue expected read responses.
  always @(negedge clk) begin
    if (!rst) begin
      exp_d = 1'b0;
      exp_c = 1'b0;
    end else begin
      exp_c = cpu_req && (!disp_req || cpu_wait >= WAIT_MAX);
      exp_d = disp_req && !exp_c;
    end
    check("disp_gnt", disp_gnt, exp_d);
    check("cpu_gnt",  cpu_gnt,  exp_c);
    check("mem_we",   mem_we,   rst ? m_we : 1'b0);
    check("mem_addr", mem_addr, rst ? m_addr : '0);
    if (rst && m_we) check("mem_wdata", mem_wdata, m_wdata);

    if (!rst) begin
      cpu_wait = 0;
      m_we     = 1'b0;
      m_addr   = '0;
      m_wdata  = '0;
      dq.delete();
      cq.delete();
    end else begin
      m_we = exp_c && cpu_we;
      if (exp_c) begin
        m_addr = cpu_addr;
        if (cpu_we) begin
          m_wdata = cpu_wdata;
          model_mem[cpu_addr] = cpu_wdata;
        end else begin
          cq.push_back('{due: cyc + 2, data: model_mem[cpu_addr]});
        end
      end else if (exp_d) begin
        m_addr = disp_addr;
        dq.push_back('{due: cyc + 2, data: model_mem[disp_addr]});
      end
      cpu_wait = (cpu_req && !exp_c) ? cpu_wait + 1 : 0;
    end

    last_d = disp_gnt;
    last_c = cpu_gnt;
    if (disp_gnt) n_dgnt++;
    if (cpu_gnt)  n_cgnt++;
    if (mem_we)   n_we++;
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    bit   d_due, c_due;
    rd_t  e;
    if (!rst) begin
      check("disp_rvalid_rst", disp_rvalid, 1'b0);
      check("cpu_rvalid_rst",  cpu_rvalid,  1'b0);
    end else begin
      d_due = (dq.size() > 0) && (dq[0].due <= cyc);
      if (disp_rvalid || d_due) begin
        check("disp_rvalid", disp_rvalid, d_due);
        if (d_due) begin
          e = dq.pop_front();
          if (disp_rvalid) check("disp_rdata", disp_rdata, e.data);
        end
      end else begin
        check("disp_rdata_idle", disp_rdata, '0);
      end

      c_due = (cq.size() > 0) && (cq[0].due <= cyc);
      if (cpu_rvalid || c_due) begin
        check("cpu_rvalid", cpu_rvalid, c_due);
        if (c_due) begin
          e = cq.pop_front();
          if (cpu_rvalid) check("cpu_rdata", cpu_rdata, e.data);
        end
      end else begin
        check("cpu_rdata_idle", cpu_rdata, '0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit dr, input logic [ADDR_W-1:0] da,
                      input bit cr, input bit cw,
                      input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd);
    disp_req  = dr;
    disp_addr = da;
    cpu_req   = cr;
    cpu_we    = cw;
    cpu_addr  = ca;
    cpu_wdata = cd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_disp_gnt"},    disp_gnt,    1'b0);
    check({tag, "_cpu_gnt"},     cpu_gnt,     1'b0);
    check({tag, "_disp_rvalid"}, disp_rvalid, 1'b0);
    check({tag, "_cpu_rvalid"},  cpu_rvalid,  1'b0);
    check({tag, "_mem_we"},      mem_we,      1'b0);
    check({tag, "_mem_addr"},    mem_addr,    '0);
    check({tag, "_mem_wdata"},   mem_wdata,   '0);
  endtask

  function automatic logic [ADDR_W-1:0] rnd_addr();
    if ($urandom_range(0, 99) < 10) return '1;
    return ADDR_W'($urandom_range(0, 31));
  endfunction

  initial begin
    int d0, c0, w0;
    rst = 1'b0;
    disp_req = 1'b1; disp_addr = 18'h00123;
    cpu_req  = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h00456; cpu_wdata = 8'hFF;
    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    idle(1);
    rst = 1'b1;
    idle(2);

    // Seed RAM through the arbiter, including the value for the CPU read.
    step(1'b0, '0, 1'b1, 1'b1, 18'h00010, 8'h5A);
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1, 1'b1, ADDR_W'(i), 8'(8'h11 * (i + 1)));
    idle(1);

    // CPU-only read of 0x00010 returns 0x5A two cycles after the grant.
    step(1'b0, '0, 1'b1, 1'b0, 18'h00010, '0);
    idle(3);

    // Both requesting every cycle: 8 display grants then one CPU grant, repeated.
    d0 = n_dgnt; c0 = n_cgnt;
    for (int i = 0; i < 27; i++) step(1'b1, ADDR_W'(i % 8), 1'b1, 1'b0, 18'h00010, '0);
    idle(3);
    check("starve_disp_count", n_dgnt - d0, 24);
    check("starve_cpu_count",  n_cgnt - c0, 3);

    // Write to the top address, then a display read of it on the next cycle.
    w0 = n_we;
    step(1'b0, '0, 1'b1, 1'b1, 18'h3FFFF, 8'hC3);
    step(1'b1, 18'h3FFFF, 1'b0, 1'b0, '0, '0);
    idle(4);
    check("raw_we_pulses", n_we - w0, 1);

    // Alternating display/CPU reads at full rate.
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) step(1'b1, ADDR_W'(i % 8), 1'b0, 1'b0, '0, '0);
      else            step(1'b0, '0, 1'b1, 1'b0, ADDR_W'(i % 8), '0);
    end
    idle(3);

    // Display read granted, then a one-cycle reset before its data would return.
    step(1'b1, 18'h00003, 1'b0, 1'b0, '0, '0);
    rst = 1'b0;
    disp_addr = 18'h00005;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 18'h00006, 1'b0, 1'b0, '0, '0);   // first cycle after reset: granted
    idle(4);

    // Randomised traffic, occasionally dropping a request before its grant.
    for (int i = 0; i < 400; i++) begin
      if (!disp_req || last_d) begin
        disp_req  = ($urandom_range(0, 99) < 60);
        disp_addr = rnd_addr();
      end else if ($urandom_range(0, 99) < 3) begin
        disp_req = 1'b0;
      end
      if (!cpu_req || last_c) begin
        cpu_req   = ($urandom_range(0, 99) < 50);
        cpu_we    = ($urandom_range(0, 1) == 1);
        cpu_addr  = rnd_addr();
        cpu_wdata = DATA_W'($urandom);
      end else if ($urandom_range(0, 99) < 3) begin
        cpu_req = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    idle(6);
    check("disp_queue_drained", dq.size(), 0);
    check("cpu_queue_drained",  cq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule

// File: doc/fb_port_arbiter.md
FB_PORT_ARBITER -- requirements
Module: fb_port_arbiter

Interface
REQ-001 SHALL provide parameter ADDR_W, default 18, framebuffer word-address width.
REQ-002 SHALL provide parameter DATA_W, default 8, pixel/data word width.
REQ-003 SHALL provide parameter WAIT_MAX, default 8, CPU starvation limit in cycles (range 1..255).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port disp_req  input  1  HDMI pixel-fetch read request, held until granted.
REQ-007 SHALL have port disp_addr  input  ADDR_W  pixel address, stable while disp_req=1.
REQ-008 SHALL have port disp_gnt  output  1  display request accepted this cycle.
REQ-009 SHALL have port disp_rvalid  output  1  disp_rdata valid this cycle.
REQ-010 SHALL have port disp_rdata  output  DATA_W  display read data.
REQ-011 SHALL have port cpu_req  input  1  processor access request, held until granted.
REQ-012 SHALL have port cpu_we  input  1  1=write, 0=read; stable while cpu_req=1.
REQ-013 SHALL have port cpu_addr  input  ADDR_W  processor address.
REQ-014 SHALL have port cpu_wdata  input  DATA_W  processor write data.
REQ-015 SHALL have port cpu_gnt  output  1  processor request accepted this cycle.
REQ-016 SHALL have port cpu_rvalid  output  1  cpu_rdata valid this cycle (reads only).
REQ-017 SHALL have port cpu_rdata  output  DATA_W  processor read data.
REQ-018 SHALL have ports mem_addr (ADDR_W), mem_we (1), mem_wdata (DATA_W) as registered outputs to single-port RAM.
REQ-019 SHALL have port mem_rdata  input  DATA_W  RAM read data, one cycle after address presented.

Function
REQ-020 Grant decision SHALL be combinational in cycle T; at most one of disp_gnt/cpu_gnt high per cycle.
REQ-021 Default priority: display; disp_req=1 -> disp_gnt=1, cpu_gnt=0.
REQ-022 cpu_gnt=1 when cpu_req=1 and (disp_req=0 or starve_cnt==WAIT_MAX).
REQ-023 starve_cnt SHALL increment when cpu_req=1 and cpu_gnt=0, saturate at WAIT_MAX, clear to 0 on cpu_gnt or cpu_req=0.
REQ-024 On grant in T, mem_addr/mem_we/mem_wdata SHALL update at end of T (RAM sees in T+1); idle cycles drive mem_we=0, mem_addr holds.
REQ-025 Read granted in T SHALL assert owner's rvalid in T+2 exactly one cycle, rdata=mem_rdata in T+2; owner tag pipelined 2 stages.
REQ-026 CPU write SHALL produce no rvalid; mem_we=1 for exactly one cycle (T+1).
REQ-027 Back-to-back grants SHALL sustain one access per cycle; read-after-write to same address returns new data (RAM write-first not required: arbiter inserts no bubble, RAM semantics apply).
REQ-028 disp_rdata/cpu_rdata SHALL equal mem_rdata when respective rvalid=1; undefined-but-stable otherwise (implementation drives 0).
REQ-029 Protocol violations (req dropped before gnt) SHALL not corrupt state; request simply not issued.

Reset
REQ-030 rst=0 SHALL immediately clear disp_gnt, cpu_gnt, disp_rvalid, cpu_rvalid, mem_we, mem_addr, mem_wdata, starve_cnt, read-tag pipeline to 0.
REQ-031 Reads in flight at reset SHALL never produce rvalid after rst returns to 1.
REQ-032 First grant possible in first cycle after rst deasserts.

Verification
REQ-033 CPU-only read addr 0x00010, RAM holds 0x5A -> cpu_gnt T, mem_addr=0x00010 T+1, cpu_rvalid=1 with 0x5A T+2, disp_rvalid=0.
REQ-034 Both req every cycle, WAIT_MAX=8 -> disp_gnt 8 cycles, cpu_gnt on 9th, starve_cnt back to 0, pattern repeats.
REQ-035 CPU write 0x3FFFF<-0xC3 then display read 0x3FFFF next cycle -> mem_we pulse once, disp_rvalid two cycles after disp_gnt with 0xC3.
REQ-036 Display read granted, rst=0 for one cycle before T+2 -> no disp_rvalid afterwards, all outputs 0 during reset.
REQ-037 Alternating disp/cpu reads at full rate -> rvalid interleaved correctly, each rdata routed to correct owner, no lost or duplicated responses.
